// File: rtl/dfsm_layer_sched.sv
// dfsm_layer_sched: queues DFSM layer configs and issues them one at a time with a start pulse.
// Optional WAIT watchdog enabled by defining DFSM_SCHED_TIMEOUT_EN.
module dfsm_layer_sched #(
  parameter int MAX_nPERIOD = 8,
  parameter int MAX_nLMAC   = 12288,
  parameter int MAX_nSHFT   = 192,
  parameter int QDEPTH      = 4,
  parameter int TIMEOUT_CYC = 65536,
  localparam int PW     = $clog2(MAX_nPERIOD),
  localparam int LW     = $clog2(MAX_nLMAC),
  localparam int SW     = $clog2(MAX_nSHFT),
  localparam int CONF_W = PW + LW + SW + 1,
  localparam int AW     = $clog2(QDEPTH),
  localparam int LVW    = AW + 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              enable_i,
  input  logic              flush_i,
  input  logic              cfg_valid_i,
  output logic              cfg_ready_o,
  input  logic [CONF_W-1:0] cfg_data_i,
  input  logic              layer_done_i,
  output logic [CONF_W-1:0] config_bits_o,
  output logic              start_o,
  output logic              dfsm_rst_o,
  output logic              busy_o,
  output logic              all_done_o,
  output logic              cfg_err_o,
  output logic              timeout_err_o,
  output logic [15:0]       done_cnt_o,
  output logic [LVW-1:0]    q_level_o
);
  typedef enum logic [1:0] {IDLE, LOAD, START, WAIT} state_e;
  state_e            state_q;
  logic [CONF_W-1:0] mem_q [QDEPTH];
  logic [AW-1:0]     wr_q, rd_q;
  logic [LVW-1:0]    lvl_q, lvl_d;
  logic [CONF_W-1:0] cfg_q;
  logic              start_q, all_done_q, cfg_err_q;
  logic [15:0]       done_cnt_q;
  logic              push, pop, bad_cfg;
`ifdef DFSM_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC);
  logic [TW-1:0] tmr_q;
  logic          timeout_err_q, dfsm_rst_q;
  assign timeout_err_o = timeout_err_q;
  assign dfsm_rst_o    = dfsm_rst_q;
`else
  // watchdog compiled out: the error can never be raised for any legal limit
  assign timeout_err_o = TIMEOUT_CYC < 0;
  assign dfsm_rst_o    = 1'b1;
`endif
  always_comb begin
    push    = cfg_valid_i && cfg_ready_o && !flush_i;
    pop     = state_q == IDLE && enable_i && lvl_q != '0 && !flush_i;
    lvl_d   = flush_i ? '0 : lvl_q + LVW'(push) - LVW'(pop);
    bad_cfg = ~|cfg_q[SW-1:0] || ~|cfg_q[SW+:LW] || ~|cfg_q[SW+LW+:PW];
  end
  assign cfg_ready_o   = lvl_q != LVW'(QDEPTH);
  assign busy_o        = state_q != IDLE;
  assign config_bits_o = cfg_q;
  assign start_o       = start_q;
  assign all_done_o    = all_done_q;
  assign cfg_err_o     = cfg_err_q;
  assign done_cnt_o    = done_cnt_q;
  assign q_level_o     = lvl_q;
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_q] <= cfg_data_i;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      wr_q       <= '0;
      rd_q       <= '0;
      lvl_q      <= '0;
      cfg_q      <= '0;
      start_q    <= 1'b0;
      all_done_q <= 1'b0;
      cfg_err_q  <= 1'b0;
      done_cnt_q <= '0;
`ifdef DFSM_SCHED_TIMEOUT_EN
      tmr_q         <= '0;
      timeout_err_q <= 1'b0;
      dfsm_rst_q    <= 1'b1;
`endif
    end else begin
      lvl_q      <= lvl_d;
      wr_q       <= flush_i ? '0 : wr_q + AW'(push);
      rd_q       <= flush_i ? '0 : rd_q + AW'(pop);
      start_q    <= 1'b0;
      all_done_q <= 1'b0;
`ifdef DFSM_SCHED_TIMEOUT_EN
      dfsm_rst_q <= 1'b1;
`endif
      case (state_q)
        IDLE: if (pop) begin
          cfg_q   <= mem_q[rd_q];
          state_q <= LOAD;
        end
        LOAD: begin
          state_q   <= bad_cfg ? IDLE : START;
          start_q   <= !bad_cfg;
          cfg_err_q <= cfg_err_q | bad_cfg;
        end
        START: begin
          state_q <= WAIT;
`ifdef DFSM_SCHED_TIMEOUT_EN
          tmr_q <= '0;
`endif
        end
        WAIT: if (layer_done_i) begin
          done_cnt_q <= done_cnt_q + 16'd1;
          all_done_q <= lvl_d == '0;
          state_q    <= IDLE;
        end
`ifdef DFSM_SCHED_TIMEOUT_EN
        else if (tmr_q == TW'(TIMEOUT_CYC - 1)) begin
          timeout_err_q <= 1'b1;
          dfsm_rst_q    <= 1'b0;
          state_q       <= IDLE;
        end else tmr_q <= tmr_q + TW'(1);
`endif
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dfsm_layer_sched.sv
// tb_dfsm_layer_sched: directed sequence with random config words checked against a queue-level model.
module tb_dfsm_layer_sched;
  localparam int PW = $clog2(8), LW = $clog2(12288), SW = $clog2(192);
  localparam int CW = PW + LW + SW + 1, QD = 4;
`ifdef DFSM_SCHED_TIMEOUT_EN
  localparam int TO = 32;
`else
  localparam int TO = 65536;
`endif
  logic clk = 0, rst_n = 0, enable = 0, flush = 0, cfg_valid = 0, layer_done = 0;
  logic [CW-1:0] cfg_data = '0;
  logic cfg_ready, start, dfsm_rst, busy, all_done, cfg_err, timeout_err;
  logic [CW-1:0] config_bits;
  logic [15:0] done_cnt;
  logic [$clog2(QD):0] q_level;
  int checks = 0, errors = 0, dcnt = 0;
  bit errm = 0, toerr = 0;
  logic [CW-1:0] mq[$];

  always #5 clk = ~clk;

  dfsm_layer_sched #(.QDEPTH(QD), .TIMEOUT_CYC(TO)) dut (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .flush_i(flush),
    .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready), .cfg_data_i(cfg_data),
    .layer_done_i(layer_done), .config_bits_o(config_bits), .start_o(start),
    .dfsm_rst_o(dfsm_rst), .busy_o(busy), .all_done_o(all_done), .cfg_err_o(cfg_err),
    .timeout_err_o(timeout_err), .done_cnt_o(done_cnt), .q_level_o(q_level)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CW-1:0] gen(bit good);
    logic [PW-1:0] p;
    logic [LW-1:0] l;
    logic [SW-1:0] s;
    int z;
    p = PW'($urandom_range(1, 7));
    l = LW'($urandom_range(1, 12287));
    s = SW'($urandom_range(1, 191));
    z = $urandom_range(0, 2);
    if (!good) begin
      if (z == 0) p = '0;
      else if (z == 1) l = '0;
      else s = '0;
    end
    return {1'($urandom), p, l, s};
  endfunction

  function automatic bit ok(logic [CW-1:0] w);
    return w[SW-1:0] != 0 && w[SW+:LW] != 0 && w[SW+LW+:PW] != 0;
  endfunction

  task automatic push(logic [CW-1:0] w);
    bit rdy;
    rdy = cfg_ready;
    cfg_valid = 1;
    cfg_data = w;
    tick();
    cfg_valid = 0;
    if (rdy) mq.push_back(w);
  endtask

  task automatic run_layer(int dly, bit kill_en, bit do_flush, bit push_done);
    logic [CW-1:0] w, prev, w2;
    bit seen, started;
    w = mq.pop_front();
    started = 0;
    if (!ok(w)) begin
      seen = busy;
      for (int n = 0; n < 8; n++) begin
        tick();
        started |= start;
        if (busy) seen = 1;
        else if (seen) break;
      end
      errm = 1;
      chk("bad_no_start", started, 0);
      chk("bad_idle", busy, 0);
      chk("bad_cfg_err", cfg_err, 1);
      chk("bad_cfg_bits", config_bits, w);
      chk("bad_done_cnt", done_cnt, dcnt[15:0]);
      return;
    end
    prev = config_bits;
    for (int n = 0; n < 8 && !start; n++) begin
      prev = config_bits;
      tick();
    end
    chk("start_seen", start, 1);
    chk("cfg_at_start", config_bits, w);
    chk("cfg_pre_start", prev, w);
    tick();
    chk("start_pulse", start, 0);
    chk("busy_wait", busy, 1);
    if (kill_en) enable = 0;
    if (do_flush) begin
      flush = 1;
      cfg_valid = 1;
      cfg_data = gen(1);
      tick();
      flush = 0;
      cfg_valid = 0;
      mq.delete();
      chk("flush_level", q_level, 0);
      chk("flush_busy", busy, 1);
    end
    repeat (dly) begin
      tick();
      started |= start;
    end
    chk("wait_no_start", started, 0);
    chk("cfg_hold", config_bits, w);
    w2 = gen(1);
    layer_done = 1;
    if (push_done) begin
      cfg_valid = 1;
      cfg_data = w2;
    end
    tick();
    layer_done = 0;
    cfg_valid = 0;
    if (push_done) mq.push_back(w2);
    dcnt++;
    chk("done_cnt", done_cnt, dcnt[15:0]);
    chk("all_done", all_done, mq.size() == 0);
    chk("busy_done", busy, 0);
    chk("level_done", q_level, mq.size());
    chk("cfg_err", cfg_err, errm);
    chk("timeout_err", timeout_err, toerr);
    chk("dfsm_rst", dfsm_rst, 1);
    tick();
    chk("all_done_pulse", all_done, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [CW-1:0] w5;
    int n;
    repeat (2) tick();
    chk("rst_busy", busy, 0);
    chk("rst_start", start, 0);
    chk("rst_cfg_bits", config_bits, 0);
    chk("rst_dfsm_rst", dfsm_rst, 1);
    chk("rst_done_cnt", done_cnt, 0);
    chk("rst_level", q_level, 0);
    chk("rst_cfg_err", cfg_err, 0);
    chk("rst_all_done", all_done, 0);
    rst_n = 1;
    tick();
    chk("rst_ready", cfg_ready, 1);
    chk("rst_timeout", timeout_err, 0);

    repeat (3) push(gen(1));
    chk("three_level", q_level, 3);
    enable = 1;
    repeat (3) run_layer(20, 0, 0, 0);

    enable = 0;
    repeat (4) push(gen(1));
    chk("full_level", q_level, 4);
    chk("full_ready", cfg_ready, 0);
    w5 = gen(1);
    cfg_valid = 1;
    cfg_data = w5;
    tick();
    chk("full_drop", q_level, 4);
    enable = 1;
    tick();
    chk("pop_ready", cfg_ready, 1);
    chk("pop_level", q_level, 3);
    tick();
    cfg_valid = 0;
    mq.push_back(w5);
    chk("refill_level", q_level, mq.size() - 1);
    repeat (5) run_layer($urandom_range(1, 30), 0, 0, 0);

    enable = 0;
    push(gen(0));
    push(gen(1));
    enable = 1;
    run_layer(0, 0, 0, 0);
    run_layer(7, 0, 0, 0);

    layer_done = 1;
    tick();
    layer_done = 0;
    chk("idle_done_ignored", done_cnt, dcnt[15:0]);
    chk("idle_no_all_done", all_done, 0);
    enable = 0;
    repeat (3) push(gen(1));
    enable = 1;
    run_layer(10, 0, 1, 0);

    enable = 0;
    repeat (2) push(gen(1));
    enable = 1;
    run_layer(5, 1, 0, 0);
    repeat (5) tick();
    chk("en_low_idle", busy, 0);
    chk("en_low_level", q_level, 1);
    enable = 1;
    run_layer(4, 0, 0, 1);
    run_layer(3, 0, 0, 0);

    for (int r = 0; r < 12; r++) begin
      enable = 0;
      n = $urandom_range(1, QD);
      repeat (n) push(gen($urandom_range(0, 4) != 0));
      chk("rand_level", q_level, mq.size());
      enable = 1;
      repeat (n) run_layer($urandom_range(0, 12), 0, 0, 0);
    end

    enable = 0;
    repeat (2) push(gen(1));
    enable = 1;
    for (int k = 0; k < 8 && !start; k++) tick();
    chk("arst_start", start, 1);
    tick();
    chk("arst_in_wait", busy, 1);
    #2 rst_n = 0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_level", q_level, 0);
    chk("arst_done_cnt", done_cnt, 0);
    chk("arst_cfg_bits", config_bits, 0);
    chk("arst_start_low", start, 0);
    chk("arst_dfsm_rst", dfsm_rst, 1);
    enable = 0;
    mq.delete();
    dcnt = 0;
    errm = 0;
    toerr = 0;
    tick();
    rst_n = 1;
    tick();
    chk("post_rst_ready", cfg_ready, 1);
    push(gen(1));
    enable = 1;
    run_layer(6, 0, 0, 0);

`ifdef DFSM_SCHED_TIMEOUT_EN
    for (int r = 0; r < 2; r++) begin
      enable = 0;
      push(gen(1));
      enable = 1;
      mq.delete();
      for (int k = 0; k < 8 && !start; k++) tick();
      chk("to_start", start, 1);
      tick();
      repeat (TO - 1) begin
        tick();
        chk("to_early", timeout_err, toerr);
      end
      if (r == 1) layer_done = 1;
      tick();
      layer_done = 0;
      if (r == 0) begin
        toerr = 1;
        chk("to_fire", timeout_err, 1);
        chk("to_dfsm_rst", dfsm_rst, 0);
      end else begin
        dcnt++;
        chk("to_limit_done", dfsm_rst, 1);
      end
      chk("to_done_cnt", done_cnt, dcnt[15:0]);
      chk("to_idle", busy, 0);
      tick();
      chk("to_rst_release", dfsm_rst, 1);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
